// File: rtl/switch_seq_driver.sv
// Upstream sequencer for the switch-lock stage: takes switch requests over valid/ready and
// drives the strobe, selection, lock window and completion pulse to the downstream switch.
module switch_seq_driver #(
  parameter int unsigned LONG_LOCK    = 4,
  parameter int unsigned SHORT_LOCK   = 2,
  parameter logic [1:0]  RESET_SELECT = 2'b00,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_select,
  output logic             switch_enb,
  output logic [1:0]       switch_select,
  output logic [1:0]       lock_enb,
  output logic             done,
  output logic             long_path,
  output logic             busy,
  output logic [CNT_W-1:0] sw_count
);

  if (LONG_LOCK == 0 || LONG_LOCK > 10) begin : g_long_lock_chk
    $error("LONG_LOCK must be in 1..10");
  end
  if (SHORT_LOCK == 0 || SHORT_LOCK > 2) begin : g_short_lock_chk
    $error("SHORT_LOCK must be in 1..2");
  end

  typedef enum logic [1:0] {StIdle, StEnb, StLock, StDone} state_e;

  localparam logic [3:0] LongLoad  = 4'(LONG_LOCK);
  localparam logic [3:0] ShortLoad = 4'(SHORT_LOCK - 1);

  state_e           r_state, w_state_next;
  logic [1:0]       r_sel, w_sel_next;
  logic             r_long, w_long_next;
  logic [3:0]       r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_sw_count, w_sw_count_next;
  logic             r_switch_enb, w_switch_enb_next;
  logic [1:0]       r_lock_enb, w_lock_enb_next;
  logic             r_done, w_done_next;

  always_comb begin
    w_state_next    = r_state;
    w_sel_next      = r_sel;
    w_long_next     = r_long;
    w_cnt_next      = r_cnt;
    w_sw_count_next = r_sw_count;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_state_next = StEnb;
          w_sel_next   = req_select;
          w_long_next  = (r_sel == 2'b11) && (req_select == 2'b00);
        end
      end
      StEnb: begin
        if (r_long) begin
          w_state_next = StLock;
          w_cnt_next   = LongLoad;
        end else if (SHORT_LOCK >= 2) begin
          // The strobe cycle already served as lock cycle 1.
          w_state_next = StLock;
          w_cnt_next   = ShortLoad;
        end else begin
          w_state_next    = StDone;
          w_sw_count_next = r_sw_count + CNT_W'(1);
        end
      end
      StLock: begin
        if (r_cnt <= 4'd1) begin
          w_state_next    = StDone;
          w_cnt_next      = 4'd0;
          w_sw_count_next = r_sw_count + CNT_W'(1);
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      StDone: begin
        w_state_next = StIdle;
        w_long_next  = 1'b0;
      end
      default: w_state_next = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    w_switch_enb_next = (w_state_next == StEnb);
    w_done_next       = (w_state_next == StDone);
    w_lock_enb_next   = ((w_state_next == StEnb && !w_long_next) || w_state_next == StLock)
                        ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_sel        <= RESET_SELECT;
      r_long       <= 1'b0;
      r_cnt        <= 4'd0;
      r_sw_count   <= '0;
      r_switch_enb <= 1'b0;
      r_lock_enb   <= 2'b00;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sel        <= w_sel_next;
      r_long       <= w_long_next;
      r_cnt        <= w_cnt_next;
      r_sw_count   <= w_sw_count_next;
      r_switch_enb <= w_switch_enb_next;
      r_lock_enb   <= w_lock_enb_next;
      r_done       <= w_done_next;
    end
  end

  assign req_ready     = (r_state == StIdle) && !rst;
  assign busy          = (r_state != StIdle);
  assign switch_enb    = r_switch_enb;
  assign switch_select = r_sel;
  assign lock_enb      = r_lock_enb;
  assign done          = r_done;
  assign long_path     = r_long;
  assign sw_count      = r_sw_count;

endmodule

// File: tb/tb_switch_seq_driver.sv
// Bench for switch_seq_driver: two configurations share stimulus and are checked every cycle
// against a sequence-position model, plus a directed table and reset/stress sequences.
module tb_switch_seq_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid;
  logic [1:0] req_select;

  logic       rdy[2];
  logic       enb[2];
  logic [1:0] ssel[2];
  logic [1:0] lock[2];
  logic       dn[2];
  logic       lp[2];
  logic       bsy[2];
  logic [7:0] cnt[2];

  switch_seq_driver #(
    .LONG_LOCK(4), .SHORT_LOCK(2), .RESET_SELECT(2'b00), .CNT_W(8)
  ) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_select(req_select), .switch_enb(enb[0]), .switch_select(ssel[0]),
    .lock_enb(lock[0]), .done(dn[0]), .long_path(lp[0]), .busy(bsy[0]), .sw_count(cnt[0])
  );

  switch_seq_driver #(
    .LONG_LOCK(4), .SHORT_LOCK(1), .RESET_SELECT(2'b11), .CNT_W(8)
  ) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_select(req_select), .switch_enb(enb[1]), .switch_select(ssel[1]),
    .lock_enb(lock[1]), .done(dn[1]), .long_path(lp[1]), .busy(bsy[1]), .sw_count(cnt[1])
  );

  int         p_long[2]  = '{4, 4};
  int         p_short[2] = '{2, 1};
  logic [1:0] p_rst[2]   = '{2'b00, 2'b11};

  // Model: position within the current sequence (-1 = idle), cycle 0 is the strobe cycle.
  int         m_pos[2];
  logic       m_long[2];
  logic [1:0] m_sel[2];
  logic [7:0] m_cnt[2];
  int         m_acc[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int seq_len(input int d);
    return m_long[d] ? p_long[d] + 1 : p_short[d];
  endfunction

  task automatic model_update(input int d, input logic v, input logic [1:0] s, input logic r);
    if (r) begin
      m_pos[d]  = -1;
      m_long[d] = 1'b0;
      m_sel[d]  = p_rst[d];
      m_cnt[d]  = 8'd0;
    end else if (m_pos[d] == -1) begin
      if (v) begin
        m_long[d] = (m_sel[d] == 2'b11) && (s == 2'b00);
        m_sel[d]  = s;
        m_pos[d]  = 0;
        m_acc[d]++;
      end
    end else if (m_pos[d] == seq_len(d)) begin
      m_pos[d]  = -1;
      m_long[d] = 1'b0;
    end else begin
      m_pos[d]++;
      if (m_pos[d] == seq_len(d)) m_cnt[d] = m_cnt[d] + 8'd1;
    end
  endtask

  task automatic compare(input int d);
    int   pos;
    logic e_lock;
    pos = m_pos[d];
    if (pos < 0) e_lock = 1'b0;
    else if (m_long[d]) e_lock = (pos >= 1) && (pos <= p_long[d]);
    else e_lock = (pos < p_short[d]);
    check($sformatf("dut%0d switch_enb", d), int'(enb[d]), int'(pos == 0));
    check($sformatf("dut%0d switch_select", d), int'(ssel[d]), int'(m_sel[d]));
    check($sformatf("dut%0d lock_enb", d), int'(lock[d]), e_lock ? 3 : 0);
    check($sformatf("dut%0d done", d), int'(dn[d]), int'(pos >= 0 && pos == seq_len(d)));
    check($sformatf("dut%0d long_path", d), int'(lp[d]), int'(pos >= 0 && m_long[d]));
    check($sformatf("dut%0d busy", d), int'(bsy[d]), int'(pos >= 0));
    check($sformatf("dut%0d sw_count", d), int'(cnt[d]), int'(m_cnt[d]));
  endtask

  // One clock: drive inputs, check req_ready, advance model at the edge, check registered outputs.
  task automatic step(input logic v, input logic [1:0] s, input logic r);
    req_valid  = v;
    req_select = s;
    rst        = r;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("dut%0d req_ready", d), int'(rdy[d]), int'(!r && m_pos[d] == -1));
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_update(d, v, s, r);
    @(negedge clk);
    for (int d = 0; d < 2; d++) compare(d);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       exp_long;
    int         exp_lat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int lat;
    int acc_start;
    int cyc;
    logic v;
    logic [1:0] s;

    // Expectations for u_dut0 (SHORT_LOCK=2, LONG_LOCK=4), starting from select 00.
    tbl[0]  = '{2'b11, 1'b0, 2};
    tbl[1]  = '{2'b00, 1'b1, 5};
    tbl[2]  = '{2'b10, 1'b0, 2};
    tbl[3]  = '{2'b00, 1'b0, 2};
    tbl[4]  = '{2'b00, 1'b0, 2};
    tbl[5]  = '{2'b01, 1'b0, 2};
    tbl[6]  = '{2'b01, 1'b0, 2};
    tbl[7]  = '{2'b11, 1'b0, 2};
    tbl[8]  = '{2'b01, 1'b0, 2};
    tbl[9]  = '{2'b11, 1'b0, 2};
    tbl[10] = '{2'b00, 1'b1, 5};

    for (int d = 0; d < 2; d++) begin
      m_pos[d] = -1; m_long[d] = 1'b0; m_sel[d] = p_rst[d]; m_cnt[d] = 8'd0; m_acc[d] = 0;
    end
    req_valid = 1'b0; req_select = 2'b00; rst = 1'b1;
    @(negedge clk);

    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].sel, 1'b0);
      check("tbl switch_enb", int'(enb[0]), 1);
      check("tbl switch_select", int'(ssel[0]), int'(tbl[i].sel));
      check("tbl long_path", int'(lp[0]), int'(tbl[i].exp_long));
      lat = 0;
      while (!dn[0] && lat < 20) begin
        step(1'b0, 2'($urandom), 1'b0);
        lat++;
      end
      check("tbl done latency", lat, tbl[i].exp_lat);
      step(1'b0, 2'b00, 1'b0);
    end

    // Reset in the middle of the long lock window.
    step(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    check("long entry switch_enb", int'(enb[0]), 1);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    check("long lock open", int'(lock[0]), 3);
    step(1'b0, 2'b00, 1'b1);
    check("rst lock_enb", int'(lock[0]), 0);
    check("rst switch_select", int'(ssel[0]), 0);
    check("rst sw_count", int'(cnt[0]), 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'b00, 1'b0);
      check("rst no done", int'(dn[0]), 0);
    end
    step(1'b1, 2'b10, 1'b0);
    check("post-rst switch_enb", int'(enb[0]), 1);
    check("post-rst switch_select", int'(ssel[0]), 2);

    // Back-to-back alternating 11/00 requests through a counter wrap.
    acc_start = m_acc[0];
    cyc = 0;
    while (m_acc[0] < acc_start + 300 && cyc < 20000) begin
      v = ($urandom_range(0, 7) != 0);
      s = (m_sel[0] == 2'b11) ? 2'b00 : 2'b11;
      if (m_pos[0] != -1 && $urandom_range(0, 3) == 0) s = 2'($urandom);
      step(v, s, 1'b0);
      cyc++;
    end
    check("stress accepts reached", int'(m_acc[0] >= acc_start + 300), 1);

    // Fully random traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      step(1'($urandom), 2'($urandom), ($urandom_range(0, 40) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_seq_driver.md
Name: switch_seq_driver

Overview:
- Upstream sequencer for the switch-lock stage.
- Accepts switch requests over a valid/ready handshake and drives `switch_enb`, `switch_select`, `lock_enb` and `done` to the downstream switch.
- Timing rule:
  - A 2'b11→2'b00 select change gets a one-cycle gap and then a long lock window.
  - Every other change gets a short lock window that starts immediately.
- Also exports status and a completed-switch counter for monitoring.

Parameters:
- LONG_LOCK, 4, lock_enb cycles on the 11→00 path; legal 1..10 (elaboration error otherwise).
- SHORT_LOCK, 2, lock_enb cycles on all other paths; legal 1..2 (elaboration error otherwise).
- RESET_SELECT, 2'b00, switch_select value after reset.
- CNT_W, 8, width of the completed-switch counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, can accept.
- req_select  in  2  requested switch selection.
- switch_enb  out  1  one-cycle strobe marking the switch cycle.
- switch_select  out  2  current selection, registered.
- lock_enb  out  2  2'b11 while lock asserted, 2'b00 otherwise.
- done  out  1  one-cycle completion pulse.
- long_path  out  1  high from switch_enb through done when the 11→00 path is in progress.
- busy  out  1  state != IDLE.
- sw_count  out  CNT_W  completed switches; wraps at 2^CNT_W-1 → 0.

Behaviour:
- Reset values (applied on any clock edge with rst=1, including mid-sequence):
  - state=IDLE, switch_select=RESET_SELECT.
  - switch_enb=0, lock_enb=2'b00, done=0, long_path=0, sw_count=0.
  - Any sequence in progress is aborted with no done pulse.
- All outputs are registered except req_ready, which is 1 iff state==IDLE and rst=0.
- Accept: req_valid && req_ready at edge k.
  - In the cycle after edge k: switch_select=req_select and switch_enb=1 for exactly that cycle.
  - In the cycle before it, switch_select holds the old value, so the downstream $past sees the previous selection.
- is_long = (old switch_select==2'b11) && (req_select==2'b00), captured at accept.
- States and transitions:
  - IDLE → ENB on accept.
  - ENB (switch_enb=1):
    - Short path: lock_enb=2'b11 in this cycle; this counts as lock cycle 1. Go to LOCK if SHORT_LOCK==2, else go to DONE.
    - Long path: lock_enb=2'b00; go to LOCK with counter loaded to LONG_LOCK.
  - LOCK:
    - lock_enb=2'b11 and the counter decrements each cycle.
    - Go to DONE after the last lock cycle.
    - Total contiguous lock cycles: SHORT_LOCK on the short path, LONG_LOCK on the long path (starting the cycle after switch_enb).
  - DONE: done=1, lock_enb=2'b00; sw_count increments (wrapping); go to IDLE.
- Latency from the switch_enb cycle E:
  - Short path: done at E+SHORT_LOCK.
  - Long path: done at E+LONG_LOCK+1.
- Minimum spacing between switch_enb strobes = path length + 2 cycles. Strobes never overlap an open sequence.
- Same-value requests (e.g. 01→01) and 00→00 follow the short path.
- Only 11→00 is long. 10→00 and 11→01 are short.
- switch_select is stable from switch_enb until the next accept.
- req_select is sampled only at accept. Changes while busy are ignored and req_ready stays 0.
- The lock counter is 4 bits and never underflows.
- long_path is cleared at the DONE→IDLE edge.

Test Plan:
1. rst for 2 cycles, then idle → switch_select=00, all strobes 0, sw_count=0, req_ready=1.
2. From 00, request 11 (SHORT_LOCK=2), switch_enb at cycle E:
   - lock_enb=11 at E and E+1; done at E+2; req_ready=1 at E+3.
   - sw_count=1, long_path=0 throughout.
3. Then request 00 (held select 11, LONG_LOCK=4):
   - lock_enb=00 at E, 11 at E+1..E+4; done at E+5.
   - long_path=1 at E..E+5; sw_count=2.
4. Request 00 from 10 → short path, done at E+2.
   - Also run with SHORT_LOCK=1: lock only at E, done at E+1.
5. rst asserted during the LOCK state of the long path:
   - Next cycle: lock_enb=00, done never pulses, switch_select=RESET_SELECT, sw_count=0.
   - A new request is accepted normally afterwards.
6. req_valid held high with alternating 11/00 for 300 switches (CNT_W=8):
   - No switch_enb during any open sequence.
   - Every 11→00 takes the long path; sw_count wraps 255→0.
   - An embedded checker for the downstream lock/done timing rules never fires.
